// File: rtl/serial_subtractor.sv
// Multi-cycle borrow-chain subtractor: diff = a - b - bin, DIGIT bits per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic [DIGIT:0]   w_sub;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // One digit per cycle; bit DIGIT of the widened difference is the borrow.
  assign w_sub = {1'b0, r_a_sh[DIGIT-1:0]} - {1'b0, r_b_sh[DIGIT-1:0]}
               - {{DIGIT{1'b0}}, r_borrow};
  // New digit enters at the MSB end; written as a shift so DIGIT==WIDTH still elaborates.
  assign w_res_next = WIDTH'({w_sub[DIGIT-1:0], r_res} >> DIGIT);
  assign w_last     = (r_count == CW'(STEPS - 1));

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid && in_ready) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      if (r_state == RUN && w_last)
        r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_count  <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> DIGIT;
          r_b_sh   <= r_b_sh >> DIGIT;
          r_res    <= w_res_next;
          r_borrow <= w_sub[DIGIT];
          r_count  <= r_count + CW'(1);
          // Visible result only changes on the RUN->DONE edge.
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_sub[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule
